// File: rtl/cnn_pkg.sv
// Shared CNN helpers: state encoding for the stream feeders and a ceil-log2
// used to size counters and address buses.
package cnn_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } feed_state_e;

    // Never returns less than 1 so a counter of depth 1 still gets a bit.
    function automatic int clogb2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dense_stream_feeder_if.sv
// Upstream beat port and downstream element strobe of the dense stream feeder.
interface dense_stream_feeder_if #(
    parameter int C          = 8,
    parameter int DATA_WIDTH = 8
);
    logic                      valid_i;
    logic [C*DATA_WIDTH-1:0]   data_i;
    logic                      ready_o;
    logic                      valid_o;
    logic [DATA_WIDTH-1:0]     data_o;
    logic                      last_o;
    logic                      overflow_o;

    modport master (
        output valid_i, data_i,
        input  ready_o, valid_o, data_o, last_o, overflow_o
    );

    modport slave (
        input  valid_i, data_i,
        output ready_o, valid_o, data_o, last_o, overflow_o
    );
endinterface

// File: rtl/feeder_buf.sv
// Frame buffer: beat-wide write port, element-wide read port. The packed
// layout makes element b*C+c land at flat index b*C+c.
module feeder_buf
    import cnn_pkg::*;
#(
    parameter int D          = 64,
    parameter int C          = 8,
    parameter int DATA_WIDTH = 8,
    localparam int N  = D / C,
    localparam int BW = clogb2(N),
    localparam int EW = clogb2(D)
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [BW-1:0]           i_waddr,
    input  logic [C*DATA_WIDTH-1:0] i_wdata,
    input  logic [EW-1:0]           i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    logic [N-1:0][C*DATA_WIDTH-1:0] r_mem;
    logic [D-1:0][DATA_WIDTH-1:0]   w_elems;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign w_elems = r_mem;
    assign o_rdata = w_elems[i_raddr];

endmodule

// File: rtl/dense_stream_feeder.sv
// Collects D elements in C-wide beats, then replays them one per GAP+1 cycles
// to a dense layer that cannot accept back-to-back elements.
module dense_stream_feeder
    import cnn_pkg::*;
#(
    parameter int D          = 64,
    parameter int C          = 8,
    parameter int GAP        = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dense_stream_feeder_if.slave  bus
);
    localparam int N  = D / C;
    localparam int BW = clogb2(N);
    localparam int EW = clogb2(D);
    localparam int GW = clogb2(GAP + 1);

    feed_state_e           r_state, w_state_nx;
    logic [BW-1:0]         r_beat, w_beat_nx;
    logic [EW-1:0]         r_elem, w_elem_nx;
    logic [GW-1:0]         r_gap, w_gap_nx;
    logic                  r_ready, w_ready_nx;
    logic                  r_valid, w_valid_nx;
    logic                  r_last, w_last_nx;
    logic                  r_ovf, w_ovf_nx;
    logic [DATA_WIDTH-1:0] r_data, w_data_nx;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_we;

    feeder_buf #(
        .D          (D),
        .C          (C),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_beat),
        .i_wdata (bus.data_i),
        .i_raddr (r_elem),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
            r_beat  <= '0;
            r_elem  <= '0;
            r_gap   <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_beat  <= w_beat_nx;
            r_elem  <= w_elem_nx;
            r_gap   <= w_gap_nx;
            r_ready <= w_ready_nx;
            r_valid <= w_valid_nx;
            r_last  <= w_last_nx;
            r_ovf   <= w_ovf_nx;
            r_data  <= w_data_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_beat_nx  = r_beat;
        w_elem_nx  = r_elem;
        w_gap_nx   = r_gap;
        w_ready_nx = 1'b0;
        w_valid_nx = 1'b0;
        w_last_nx  = 1'b0;
        w_data_nx  = r_data;
        w_we       = 1'b0;
        // Beats offered while not ready are dropped but remembered forever.
        w_ovf_nx   = r_ovf | (bus.valid_i & ~r_ready);

        case (r_state)
            FILL: begin
                w_ready_nx = 1'b1;
                if (bus.valid_i && r_ready) begin
                    w_we = 1'b1;
                    if (r_beat == BW'(N - 1)) begin
                        w_beat_nx  = '0;
                        w_ready_nx = 1'b0;
                        w_state_nx = DRAIN;
                    end else begin
                        w_beat_nx = r_beat + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (r_gap == '0) begin
                    w_valid_nx = 1'b1;
                    w_data_nx  = w_rdata;
                    w_last_nx  = (r_elem == EW'(D - 1));
                    w_gap_nx   = GW'(GAP);
                    if (r_elem == EW'(D - 1)) begin
                        w_elem_nx  = '0;
                        w_gap_nx   = '0;
                        w_state_nx = FILL;
                    end else begin
                        w_elem_nx = r_elem + 1'b1;
                    end
                end else begin
                    w_gap_nx = r_gap - 1'b1;
                end
            end
            default: w_state_nx = FILL;
        endcase
    end

    assign bus.ready_o    = r_ready;
    assign bus.valid_o    = r_valid;
    assign bus.data_o     = r_data;
    assign bus.last_o     = r_last;
    assign bus.overflow_o = r_ovf;

endmodule

// File: tb/tb_dense_stream_feeder.sv
// Bench for dense_stream_feeder: GAP=1 and GAP=3 instances sharing stimulus,
// with a per-instance scoreboard checking data, last, spacing and latency.
module tb_dense_stream_feeder;
    localparam int D  = 64;
    localparam int C  = 8;
    localparam int N  = D / C;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst1, rst3;
    logic en3;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;
    int   pc1, pc3, prev1, prev3, first1, first3, t_last;
    bit   rdy_chk1, rdy_chk3;

    typedef struct {
        int   mode;
        int   max_idle;
        bit   inject;
        int   exp_pulses;
        int   exp_span;
        logic exp_ovf;
    } vec_t;
    vec_t vt[4];

    dense_stream_feeder_if #(.C(C), .DATA_WIDTH(DW)) bus1();
    dense_stream_feeder_if #(.C(C), .DATA_WIDTH(DW)) bus3();

    assign bus3.valid_i = bus1.valid_i & en3;
    assign bus3.data_i  = bus1.data_i;

    dense_stream_feeder #(.D(D), .C(C), .GAP(1), .DATA_WIDTH(DW)) dut1 (
        .clk (clk), .rst (rst1), .bus (bus1)
    );
    dense_stream_feeder #(.D(D), .C(C), .GAP(3), .DATA_WIDTH(DW)) dut3 (
        .clk (clk), .rst (rst3), .bus (bus3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [DW-1:0] ev(input int mode, input int k);
        case (mode)
            1:       return (k % 2 == 0) ? 8'h80 : 8'h7F;
            2:       return 8'(100 + k);
            default: return 8'(k);
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus1.valid_o) begin
            if (q1.size() == 0) check("d1_extra_pulse", 1, 0);
            else begin
                e1 = q1.pop_front();
                check("d1_data", {24'd0, bus1.data_o}, {24'd0, e1.d});
                check("d1_last", {31'd0, bus1.last_o}, {31'd0, e1.l});
            end
            if (pc1 == 0) begin
                check("d1_first_latency", cyc - t_last, 1);
                first1 = cyc;
            end else check("d1_spacing", cyc - prev1, 2);
            prev1 = cyc;
            pc1++;
            if (bus1.last_o) rdy_chk1 = 1'b1;
        end else if (rdy_chk1) begin
            check("d1_ready_after_last", {31'd0, bus1.ready_o}, 1);
            rdy_chk1 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus3.valid_o) begin
            if (q3.size() == 0) check("d3_extra_pulse", 1, 0);
            else begin
                e3 = q3.pop_front();
                check("d3_data", {24'd0, bus3.data_o}, {24'd0, e3.d});
                check("d3_last", {31'd0, bus3.last_o}, {31'd0, e3.l});
            end
            if (pc3 == 0) begin
                check("d3_first_latency", cyc - t_last, 1);
                first3 = cyc;
            end else check("d3_spacing", cyc - prev3, 4);
            prev3 = cyc;
            pc3++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 1000; i++) begin
            if (bus1.ready_o && (!en3 || bus3.ready_o)) break;
            tick();
        end
        check("ready_timeout", i, (i < 1000) ? i : 0);
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (q1.size() == 0 && q3.size() == 0) break;
            tick();
        end
        check("drain_timeout", q1.size() + q3.size(), 0);
        repeat (3) tick();
    endtask

    task automatic send_frame(input int mode, input int max_idle);
        logic [C*DW-1:0] beat;
        pc1 = 0;
        pc3 = 0;
        for (int b = 0; b < N; b++) begin
            repeat ($urandom_range(max_idle, 0)) tick();
            for (int c = 0; c < C; c++) begin
                beat[c*DW +: DW] = ev(mode, b*C + c);
                q1.push_back('{d: ev(mode, b*C + c), l: (b*C + c == D - 1)});
                if (en3) q3.push_back('{d: ev(mode, b*C + c), l: (b*C + c == D - 1)});
            end
            bus1.valid_i = 1'b1;
            bus1.data_i  = beat;
            tick();
            t_last = cyc;
            bus1.valid_i = 1'b0;
        end
    endtask

    task automatic wait_pulses(input int n);
        int i;
        for (i = 0; i < 1000; i++) begin
            if (pc1 >= n) break;
            tick();
        end
        check("pulse_wait_timeout", pc1, n);
    endtask

    initial begin
        int saved;
        vt[0] = '{mode: 0, max_idle: 0, inject: 1'b0, exp_pulses: 64, exp_span: 127, exp_ovf: 1'b0};
        vt[1] = '{mode: 1, max_idle: 0, inject: 1'b0, exp_pulses: 64, exp_span: 127, exp_ovf: 1'b0};
        vt[2] = '{mode: 0, max_idle: 3, inject: 1'b0, exp_pulses: 64, exp_span: 127, exp_ovf: 1'b0};
        vt[3] = '{mode: 0, max_idle: 0, inject: 1'b1, exp_pulses: 64, exp_span: 127, exp_ovf: 1'b1};

        rst1 = 1'b1;
        rst3 = 1'b1;
        en3  = 1'b0;
        bus1.valid_i = 1'b0;
        bus1.data_i  = '0;
        pc1 = 0; pc3 = 0; t_last = 0;
        rdy_chk1 = 1'b0; rdy_chk3 = 1'b0;

        repeat (3) tick();
        check("rst_ready", {31'd0, bus1.ready_o}, 0);
        check("rst_valid", {31'd0, bus1.valid_o}, 0);
        check("rst_data", {24'd0, bus1.data_o}, 0);
        check("rst_last", {31'd0, bus1.last_o}, 0);
        check("rst_ovf", {31'd0, bus1.overflow_o}, 0);
        rst1 = 1'b0;
        check("ready_low_at_release", {31'd0, bus1.ready_o}, 0);
        tick();
        check("ready_first_edge", {31'd0, bus1.ready_o}, 1);

        for (int v = 0; v < 4; v++) begin
            wait_ready();
            send_frame(vt[v].mode, vt[v].max_idle);
            check("ready_low_in_drain", {31'd0, bus1.ready_o}, 0);
            if (vt[v].inject) begin
                wait_pulses(11);
                bus1.valid_i = 1'b1;
                bus1.data_i  = {C{8'hEE}};
                tick();
                bus1.valid_i = 1'b0;
                check("ovf_set", {31'd0, bus1.overflow_o}, 1);
            end
            wait_drain();
            check("frame_pulses", pc1, vt[v].exp_pulses);
            check("frame_span", prev1 - first1 + 1, vt[v].exp_span);
            check("frame_ovf", {31'd0, bus1.overflow_o}, {31'd0, vt[v].exp_ovf});
            check("data_hold", {24'd0, bus1.data_o}, {24'd0, ev(vt[v].mode, D - 1)});
        end
        repeat (10) tick();
        check("ovf_sticky", {31'd0, bus1.overflow_o}, 1);

        wait_ready();
        send_frame(0, 0);
        wait_pulses(21);
        saved = pc1;
        rst1 = 1'b1;
        #1;
        check("midrst_valid", {31'd0, bus1.valid_o}, 0);
        check("midrst_data", {24'd0, bus1.data_o}, 0);
        check("midrst_last", {31'd0, bus1.last_o}, 0);
        check("midrst_ready", {31'd0, bus1.ready_o}, 0);
        check("midrst_ovf", {31'd0, bus1.overflow_o}, 0);
        q1.delete();
        repeat (5) tick();
        rst1 = 1'b0;
        check("midrst_ready_release", {31'd0, bus1.ready_o}, 0);
        tick();
        check("midrst_ready_up", {31'd0, bus1.ready_o}, 1);
        repeat (10) tick();
        check("midrst_no_pulses", pc1, saved);
        send_frame(2, 0);
        wait_drain();
        check("postrst_pulses", pc1, 64);
        check("postrst_ovf", {31'd0, bus1.overflow_o}, 0);

        rst3 = 1'b0;
        en3  = 1'b1;
        tick();
        wait_ready();
        send_frame(0, 1);
        wait_drain();
        check("gap3_pulses", pc3, 64);
        check("gap3_span", prev3 - first3 + 1, 253);
        check("gap1_pulses_shared", pc1, 64);
        check("gap1_span_shared", prev1 - first1 + 1, 127);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
